reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every register and data port.
REQ-002 Parameter REG_NUM, default 32: register count; address width is log2(REG_NUM), which is 5 at the default.
REQ-003 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  in  1: asynchronous, active-low reset (RST_ENABLE = 0).
REQ-005 Port reg_read_en_1  in  1: read request, port 1.
REQ-006 Port reg_addr_1  in  5: read address, port 1.
REQ-007 Port reg_data_1  out  32: read data, port 1.
REQ-008 Port reg_read_en_2  in  1: read request, port 2.
REQ-009 Port reg_addr_2  in  5: read address, port 2.
REQ-010 Port reg_data_2  out  32: read data, port 2.
REQ-011 Port issue_en  in  1: decode stage commits an instruction that will write a register.
REQ-012 Port issue_addr  in  5: destination register of the issued instruction.
REQ-013 Port write_reg_en  in  1: write-back enable.
REQ-014 Port write_reg_addr  in  5: write-back address.
REQ-015 Port write_data  in  32: write-back data.
REQ-016 Port flush  in  1: discard every outstanding reservation.
REQ-017 Port busy_1  out  1: port-1 operand has a write outstanding.
REQ-018 Port busy_2  out  1: port-2 operand has a write outstanding.

Function
REQ-019 Reads SHALL be combinational (0-cycle); reg_data_n = 0 when reg_read_en_n = 0 or reg_addr_n = 0.
REQ-020 Writes SHALL commit at the rising clk edge when write_reg_en = 1 and write_reg_addr != 0; writes to register 0 SHALL be ignored.
REQ-021 Bypass: when write_reg_en = 1, write_reg_addr = reg_addr_n and the address is nonzero, reg_data_n SHALL equal write_data in the same cycle.
REQ-022 Reservation: one busy bit per register; issue_en = 1 with nonzero issue_addr SHALL set bit[issue_addr] at the edge.
REQ-023 write_reg_en = 1 SHALL clear bit[write_reg_addr] at the edge.
REQ-024 Simultaneous issue and write to the same address: set SHALL win and the bit stays 1, because the new producer owns the register.
REQ-025 flush = 1 SHALL clear all busy bits at the edge; a set requested in the same cycle SHALL be ignored; a write in the same cycle still commits its data.
REQ-026 busy_n = bit[reg_addr_n] & reg_read_en_n & ~(bypass hit on port n); it SHALL be 0 for address 0.
REQ-027 Both read ports MAY address the same register; each SHALL resolve independently.
REQ-028 Bit 0 SHALL never be set.

Reset
REQ-029 rst = 0 SHALL asynchronously clear all registers and all busy bits.
REQ-030 While rst = 0, reg_data_1, reg_data_2, busy_1 and busy_2 SHALL all be 0, and writes and issues SHALL be ignored.
REQ-031 On release, state SHALL be usable from the first rising edge; reset asserted mid-write SHALL discard that write.

Structure
REQ-032 DATA_BUS, REG_ADDR_BUS, ZERO_WORD, ZERO_REG_ADDR, RST_ENABLE, READ_ENABLE and WRITE_ENABLE SHALL come from the shared global definitions; no local redefinition.
REQ-033 The reservation bits SHALL live in one sub-module, reg_scoreboard (set, clear, flush, two lookup ports); storage and bypass SHALL stay in reg_file.

Verification
REQ-034 Reset held, all ports driven -> data = 0 and busy = 0; after release, reading r1..r31 returns 0.
REQ-035 Write r5 = 0xDEADBEEF with port 1 reading r5 in the same cycle -> reg_data_1 = 0xDEADBEEF that cycle (bypass) and the next (stored).
REQ-036 Write r0 = 0xFFFFFFFF, then read r0 on both ports -> 0; issue r0 -> busy stays 0.
REQ-037 Issue r7; next cycle read r7 -> busy_1 = 1; write r7 = 0x12 -> busy_1 = 0 with data 0x12 in the write cycle; the bit is clear afterwards.
REQ-038 Issue r9 and write r9 in the same cycle -> bit[r9] = 1 after the edge; a later write to r9 clears it.
REQ-039 Issue r3 and r4, then flush together with issue r6 -> r3, r4 and r6 all not busy; assert rst mid-sequence -> all state is 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file definitions: bus types, zero constants and enable polarities.
// Imported by the interface, the reservation scoreboard and the register file.
package reg_file_pkg;

    localparam int unsigned DATA_WIDTH_G = 32;
    localparam int unsigned REG_NUM_G    = 32;
    localparam int unsigned ADDR_WIDTH_G = $clog2(REG_NUM_G);

    typedef logic [DATA_WIDTH_G-1:0] DATA_BUS;
    typedef logic [ADDR_WIDTH_G-1:0] REG_ADDR_BUS;

    localparam DATA_BUS     ZERO_WORD     = '0;
    localparam REG_ADDR_BUS ZERO_REG_ADDR = '0;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic READ_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: two read ports, issue reservation, write-back and flush.
// master drives requests and consumes read data/busy; slave is the register file.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_G,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_G
) ();

    logic                  reg_read_en_1;
    logic [ADDR_WIDTH-1:0] reg_addr_1;
    logic [DATA_WIDTH-1:0] reg_data_1;
    logic                  busy_1;

    logic                  reg_read_en_2;
    logic [ADDR_WIDTH-1:0] reg_addr_2;
    logic [DATA_WIDTH-1:0] reg_data_2;
    logic                  busy_2;

    logic                  issue_en;
    logic [ADDR_WIDTH-1:0] issue_addr;

    logic                  write_reg_en;
    logic [ADDR_WIDTH-1:0] write_reg_addr;
    logic [DATA_WIDTH-1:0] write_data;

    logic                  flush;

    modport master (
        output reg_read_en_1, reg_addr_1,
        output reg_read_en_2, reg_addr_2,
        output issue_en, issue_addr,
        output write_reg_en, write_reg_addr, write_data,
        output flush,
        input  reg_data_1, busy_1,
        input  reg_data_2, busy_2
    );

    modport slave (
        input  reg_read_en_1, reg_addr_1,
        input  reg_read_en_2, reg_addr_2,
        input  issue_en, issue_addr,
        input  write_reg_en, write_reg_addr, write_data,
        input  flush,
        output reg_data_1, busy_1,
        output reg_data_2, busy_2
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register reservation bits: set on issue, cleared on write-back, flushed wholesale.
// Two combinational lookup ports report the raw bit for each read address.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned REG_NUM    = REG_NUM_G,
    parameter int unsigned ADDR_WIDTH = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] look_addr_1,
    input  logic [ADDR_WIDTH-1:0] look_addr_2,
    output logic                  hit_1_c,
    output logic                  hit_2_c
);

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Clear first so a same-address issue overrides it; flush drops any new set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end else if (set_en && (set_addr != ADDR_WIDTH'(ZERO_REG_ADDR))) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        hit_1_c = busy_q[look_addr_1];
        hit_2_c = busy_q[look_addr_2];
    end

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with write-back bypass and r0 hardwired to zero.
// Busy flags come from the reservation scoreboard, masked by read enable and bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_G,
    parameter int unsigned REG_NUM    = REG_NUM_G
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  bus
);

    localparam int unsigned ADDR_WIDTH = $clog2(REG_NUM);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    logic                  run;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [ADDR_WIDTH-1:0] addr_2;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_live;
    logic                  rd_live_1;
    logic                  rd_live_2;
    logic                  bypass_1;
    logic                  bypass_2;
    logic                  hit_1;
    logic                  hit_2;

    assign run     = (rst != RST_ENABLE);
    assign addr_1  = bus.reg_addr_1;
    assign addr_2  = bus.reg_addr_2;
    assign wr_addr = bus.write_reg_addr;
    assign wr_data = bus.write_data;
    assign wr_live = (bus.write_reg_en == WRITE_ENABLE) &&
                     (wr_addr != ADDR_WIDTH'(ZERO_REG_ADDR));

    // r0 is never written, so its reset value of zero holds forever.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    reg_scoreboard #(
        .REG_NUM    (REG_NUM),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (bus.issue_en),
        .set_addr    (bus.issue_addr),
        .clr_en      (bus.write_reg_en == WRITE_ENABLE),
        .clr_addr    (wr_addr),
        .flush       (bus.flush),
        .look_addr_1 (addr_1),
        .look_addr_2 (addr_2),
        .hit_1_c     (hit_1),
        .hit_2_c     (hit_2)
    );

    always_comb begin
        rd_live_1 = run && (bus.reg_read_en_1 == READ_ENABLE) &&
                    (addr_1 != ADDR_WIDTH'(ZERO_REG_ADDR));
        rd_live_2 = run && (bus.reg_read_en_2 == READ_ENABLE) &&
                    (addr_2 != ADDR_WIDTH'(ZERO_REG_ADDR));
        bypass_1  = wr_live && (wr_addr == addr_1);
        bypass_2  = wr_live && (wr_addr == addr_2);
    end

    // A bypass hit means the producer is completing now, so the operand is not busy.
    always_comb begin
        bus.reg_data_1 = DATA_WIDTH'(ZERO_WORD);
        bus.reg_data_2 = DATA_WIDTH'(ZERO_WORD);
        bus.busy_1     = 1'b0;
        bus.busy_2     = 1'b0;
        if (rd_live_1) begin
            bus.reg_data_1 = bypass_1 ? wr_data : regs[addr_1];
            bus.busy_1     = hit_1 && !bypass_1;
        end
        if (rd_live_2) begin
            bus.reg_data_2 = bypass_2 ? wr_data : regs[addr_2];
            bus.busy_2     = hit_2 && !bypass_2;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Randomized and directed bench for reg_file against an array-based reference model.
// The driver queues the expected read response each cycle; a monitor pops and compares.
module tb_reg_file;

    typedef struct {
        int          cyc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
    } exp_t;

    logic clk;
    logic rst;

    reg_file_if bus ();

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        expq[$];
    event        chk_ev;
    int          total = 0;
    int          bad   = 0;
    int          ncyc  = 0;

    logic [31:0] mregs [32];
    bit          mbusy [32];

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'h0;
            mbusy[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] model_data(input logic r, input logic e, input int a,
                                               input logic w, input int wa, input logic [31:0] wd);
        if (!r || !e || a == 0) return 32'h0;
        if (w && wa == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic model_busy(input logic r, input logic e, input int a,
                                        input logic w, input int wa);
        if (!r || !e || a == 0) return 1'b0;
        if (w && wa == a) return 1'b0;
        return mbusy[a];
    endfunction

    // One clock: drive at negedge, queue the expected response, then advance the model.
    task automatic cyc(input logic r, input logic e1, input int a1, input logic e2, input int a2,
                       input logic is, input int ia, input logic w, input int wa,
                       input logic [31:0] wd, input logic f);
        exp_t e;
        @(negedge clk);
        rst                = r;
        bus.reg_read_en_1  = e1;
        bus.reg_addr_1     = 5'(a1);
        bus.reg_read_en_2  = e2;
        bus.reg_addr_2     = 5'(a2);
        bus.issue_en       = is;
        bus.issue_addr     = 5'(ia);
        bus.write_reg_en   = w;
        bus.write_reg_addr = 5'(wa);
        bus.write_data     = wd;
        bus.flush          = f;
        if (!r) model_clear();
        e.cyc = ncyc;
        e.d1  = model_data(r, e1, a1, w, wa, wd);
        e.d2  = model_data(r, e2, a2, w, wa, wd);
        e.b1  = model_busy(r, e1, a1, w, wa);
        e.b2  = model_busy(r, e2, a2, w, wa);
        expq.push_back(e);
        -> chk_ev;
        ncyc++;
        if (r) begin
            if (w && wa != 0) mregs[wa] = wd;
            if (f) begin
                for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
            end else begin
                if (w) mbusy[wa] = 1'b0;
                if (is && ia != 0) mbusy[ia] = 1'b1;
            end
        end
    endtask

    task automatic rd(input int a1, input int a2);
        cyc(1'b1, 1'b1, a1, 1'b1, a2, 1'b0, 0, 1'b0, 0, 32'h0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL queue: response with no expectation, got empty want nonempty");
            end else begin
                e = expq.pop_front();
                total++;
                if (bus.reg_data_1 !== e.d1) begin
                    bad++;
                    $display("FAIL data_1 cyc %0d: got %h want %h", e.cyc, bus.reg_data_1, e.d1);
                end
                total++;
                if (bus.reg_data_2 !== e.d2) begin
                    bad++;
                    $display("FAIL data_2 cyc %0d: got %h want %h", e.cyc, bus.reg_data_2, e.d2);
                end
                total++;
                if (bus.busy_1 !== e.b1) begin
                    bad++;
                    $display("FAIL busy_1 cyc %0d: got %b want %b", e.cyc, bus.busy_1, e.b1);
                end
                total++;
                if (bus.busy_2 !== e.b2) begin
                    bad++;
                    $display("FAIL busy_2 cyc %0d: got %b want %b", e.cyc, bus.busy_2, e.b2);
                end
            end
        end
    end

    initial begin : driver
        rst                = 1'b0;
        bus.reg_read_en_1  = 1'b0;
        bus.reg_addr_1     = '0;
        bus.reg_read_en_2  = 1'b0;
        bus.reg_addr_2     = '0;
        bus.issue_en       = 1'b0;
        bus.issue_addr     = '0;
        bus.write_reg_en   = 1'b0;
        bus.write_reg_addr = '0;
        bus.write_data     = '0;
        bus.flush          = 1'b0;
        model_clear();

        // Reset held with every port active.
        cyc(1'b0, 1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b1, 5, 32'hA5A5A5A5, 1'b0);
        cyc(1'b0, 1'b1, 3, 1'b1, 7, 1'b1, 7, 1'b1, 3, 32'h5A5A5A5A, 1'b0);
        for (int i = 1; i < 32; i++) rd(i, 32 - i);

        // Write with same-cycle bypass, then stored value.
        cyc(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0);
        rd(5, 5);

        // r0 ignores writes and issues.
        cyc(1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b1, 0, 32'hFFFFFFFF, 1'b0);
        rd(0, 0);
        cyc(1'b1, 1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b0, 0, 32'h0, 1'b0);
        rd(0, 0);

        // Issue r7, observe busy, resolve with write-back.
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 7, 1'b0, 0, 32'h0, 1'b0);
        rd(7, 7);
        cyc(1'b1, 1'b1, 7, 1'b1, 7, 1'b0, 0, 1'b1, 7, 32'h12, 1'b0);
        rd(7, 5);

        // Issue and write r9 together: set wins.
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 9, 1'b1, 9, 32'h99, 1'b0);
        rd(9, 9);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 9, 32'h999, 1'b0);
        rd(9, 9);

        // Flush beats a concurrent issue; a concurrent write still lands.
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0, 0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
        rd(3, 4);
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 6, 1'b1, 11, 32'h0BADF00D, 1'b1);
        rd(3, 4);
        rd(6, 11);

        // Reset mid-write discards the write and all reservations.
        cyc(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0, 0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 10, 1'b1, 3, 1'b0, 0, 1'b1, 10, 32'h77777777, 1'b0);
        rd(10, 3);
        rd(5, 11);

        // Randomized traffic, concentrated on a few registers to provoke hits.
        for (int n = 0; n < 400; n++) begin
            logic r;
            int   a1, a2, ia, wa;
            r  = ($urandom_range(0, 99) != 0);
            a1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            ia = int'($urandom_range(0, 7));
            wa = int'($urandom_range(0, 7));
            cyc(r, 1'($urandom_range(0, 4) != 0), a1, 1'($urandom_range(0, 4) != 0), a2,
                1'($urandom_range(0, 2) == 0), ia, 1'($urandom_range(0, 2) == 0), wa,
                $urandom, 1'($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        #2;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
